h_bdy_eng_ret: RTL
==================

// Module: h_bdy_eng_ret
//
// PURPOSE
// - Return path of the body engine: collects results from the ENGS_N execution engines and retires them in issue order.
// - Hands out sequential tags at dispatch time, holds out-of-order completions in a reorder buffer (ROB), and emits results in tag order.
// - Sits between the engine array and the downstream consumer. It is the completion-side counterpart of dispatch/allocation.
//
// PARAMETERS
// - ENGS_N   4   number of execution engines (completion ports); defaults from cfg_pkg::ENGS_N
// - TAG_W    3   tag width; ROB depth DEPTH = 2**TAG_W
// - DAT_W    32  result payload width
//
// PORTS
// - clk            in   1              clock
// - arst_n         in   1              reset, asynchronous, active-low
// - iss_vld        in   1              dispatch requests a tag
// - iss_rdy        out  1              a tag is available (ROB not full)
// - iss_tag        out  TAG_W          tag granted on iss_vld & iss_rdy
// - cmp_vld        in   ENGS_N         per-engine completion strobe
// - cmp_tag        in   ENGS_N*TAG_W   per-engine completion tag
// - cmp_dat        in   ENGS_N*DAT_W   per-engine completion payload
// - out_vld        out  1              in-order result valid
// - out_rdy        in   1              downstream accepts the result
// - out_tag        out  TAG_W          tag of the retiring result
// - out_dat        out  DAT_W          payload of the retiring result
// - err            out  1              sticky protocol-violation flag
//
// BEHAVIOUR
// - Pointers:
//   - hd_q (retire) and tl_q (issue) are TAG_W+1 bits wide; the MSB is the wrap bit.
//   - empty = (hd_q == tl_q).
//   - full = same index bits and differing MSB.
// - Issue:
//   - iss_rdy = !full, taken from registered state only. A retire in the same cycle does not raise iss_rdy.
//   - iss_tag = tl_q[TAG_W-1:0].
//   - On fire, tl_q increments and done[tag] is cleared.
// - Completion:
//   - Each engine i with cmp_vld[i] writes dat[cmp_tag_i] and sets done[cmp_tag_i] at the next edge.
//   - Any number of engines may complete in one cycle, each to a distinct tag.
// - Retire:
//   - out_vld = !empty & done[hd_q].
//   - out_tag = hd_q index; out_dat = dat[hd_q], read directly from flops.
//   - On out_vld & out_rdy: hd_q increments and done[hd_q] clears.
//   - out_dat is held stable while out_vld & !out_rdy.
// - Latency:
//   - A completion to the head tag yields out_vld the cycle after cmp_vld. No combinational bypass.
//   - Back-to-back retire is 1 per cycle when done bits are set.
// - Simultaneous events:
//   - Issue, retire and completions may coincide.
//   - Issue to slot k and retire of slot k cannot coincide, because full blocks issue.
// - Errors (err sets and stays set until reset; the ROB update is suppressed for the offending port):
//   - Completion to a tag not outstanding (outside [hd_q, tl_q)).
//   - Completion to a tag whose done bit is already set.
//   - Two engines completing the same tag in one cycle. The lowest index wins and the others are dropped.
// - Wrap-around: indices wrap modulo DEPTH. Outstanding-range checks use the wrap bit.
// - Reset (async assert, any time):
//   - hd_q = tl_q = 0, done = 0, err = 0.
//   - iss_rdy = 1, iss_tag = 0, out_vld = 0, out_tag = 0.
//   - dat is not reset, so out_dat is unspecified while out_vld = 0.
//   - In-flight completions are discarded.
//
// STRUCTURE
// - h_pkg:
//   - typedef h_tag_t (TAG_W-bit index).
//   - typedef h_ptr_t (TAG_W+1-bit pointer).
//   - function h_in_flight(ptr hd, ptr tl, tag t) for the outstanding-range check.
// - cfg_pkg: ENGS_N, TAG_W, DAT_W defaults.
// - One sub-module, h_bdy_eng_ret_rob:
//   - DEPTH x DAT_W payload flops plus done vector.
//   - ENGS_N write ports, one read port.
//   - Write-port dedup priority lives in the sub-module.
// - Top: pointer logic, issue/retire handshakes, error detection.
//
// TESTING
// - In-order single engine: issue tags 0..3, complete 0..3 one per cycle, out_rdy=1
//   -> out_tag 0,1,2,3 on consecutive cycles, each 1 cycle after its completion.
// - Reverse completion: issue 0..7 (full, iss_rdy=0), complete 7..0 on engine 0
//   -> no out_vld until tag 0 completes, then 8 back-to-back retires; iss_rdy=1 the cycle after the first retire.
// - Parallel completion: 4 engines complete tags 1,2,3,0 in one cycle -> out_tag 0,1,2,3 on the next 4 cycles.
// - Backpressure/wrap: 20 issues with random out_rdy stalls
//   -> payload is held while stalled, tags wrap 7->0, order is preserved, err=0.
// - Errors:
//   - Completing tag 5 with only 0..2 outstanding -> err=1 next cycle and the ROB is unchanged.
//   - Engines 0 and 2 both completing tag 1 -> err=1 and engine 0's data is retained.
// - Reset mid-operation: arst_n low with 5 outstanding, 2 done
//   -> out_vld=0, iss_rdy=1, iss_tag=0 immediately; the first post-reset issue gets tag 0.

Source files
------------

// File: rtl/h_bdy_eng_ret_pkg.sv
// Shared types and defaults for the body-engine return path (reorder buffer).
// Provides the tag/pointer types, the default engine count and payload
// width, and the outstanding-range helper used by the top-level error check.
package h_bdy_eng_ret_pkg;

    localparam int ENGS_N_DEF = 4;
    localparam int DAT_W_DEF  = 32;
    localparam int TAG_W      = 3;
    localparam int DEPTH      = 2 ** TAG_W;

    // Tag: index into the ROB.  Pointer: index plus a wrap bit in the MSB.
    typedef logic [TAG_W-1:0] h_tag_t;
    typedef logic [TAG_W:0]   h_ptr_t;

    localparam h_ptr_t PTR_ZERO = h_ptr_t'(0);
    localparam h_ptr_t PTR_ONE  = h_ptr_t'(1);

    // True when tag t lies in the outstanding window [hd, tl).  The distance
    // of t from the head index (mod DEPTH) must be below the occupancy, which
    // the wrap bit makes exact even when the ROB is full.
    function automatic logic h_in_flight(input h_ptr_t hd, input h_ptr_t tl, input h_tag_t t);
        h_ptr_t occ;
        h_tag_t off;
        occ = tl - hd;
        off = t - hd[TAG_W-1:0];
        return ({1'b0, off} < occ);
    endfunction

endpackage

// File: rtl/h_bdy_eng_ret_rob.sv
// Reorder-buffer storage: DEPTH x DAT_W payload flops plus a done vector.
// Ports:
//   wr_en_i/wr_tag_i/wr_dat_i  ENGS_N completion write ports (already legality-filtered)
//   iss_clr_i/iss_tag_i        clear done for a freshly issued tag
//   ret_clr_i/ret_tag_i        clear done for the retiring tag
//   rd_tag_i/rd_dat_o          single read port (direct flop read)
//   done_o                     registered done vector
//   dup_o                      write ports dropped because a lower port hit the same tag
module h_bdy_eng_ret_rob
    import h_bdy_eng_ret_pkg::*;
#(
    parameter int ENGS_N = ENGS_N_DEF,
    parameter int DAT_W  = DAT_W_DEF
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic [ENGS_N-1:0]         wr_en_i,
    input  logic [ENGS_N*TAG_W-1:0]   wr_tag_i,
    input  logic [ENGS_N*DAT_W-1:0]   wr_dat_i,
    input  logic                      iss_clr_i,
    input  logic [TAG_W-1:0]          iss_tag_i,
    input  logic                      ret_clr_i,
    input  logic [TAG_W-1:0]          ret_tag_i,
    input  logic [TAG_W-1:0]          rd_tag_i,
    output logic [DAT_W-1:0]          rd_dat_o,
    output logic [DEPTH-1:0]          done_o,
    output logic [ENGS_N-1:0]         dup_o
);

    logic [DAT_W-1:0] dat_q [DEPTH];
    logic [DEPTH-1:0] done_q;
    logic [DEPTH-1:0] done_d;
    logic [DEPTH-1:0] set_s;
    logic [DEPTH-1:0] clr_s;
    logic [ENGS_N-1:0] we_s;

    localparam logic [DEPTH-1:0] ONE_HOT0 = {{(DEPTH-1){1'b0}}, 1'b1};

    // Same-tag dedup: a port is kept only if no lower-indexed port targets its tag.
    always_comb begin
        we_s = wr_en_i;
        for (int i = 0; i < ENGS_N; i++) begin
            for (int j = 0; j < i; j++) begin
                we_s[i] = we_s[i] & ~(wr_en_i[j] &&
                          (wr_tag_i[j*TAG_W +: TAG_W] == wr_tag_i[i*TAG_W +: TAG_W]));
            end
        end
    end

    assign dup_o = wr_en_i & ~we_s;

    // Done-vector next state: clears from issue/retire, sets from surviving writes.
    always_comb begin
        set_s = {DEPTH{1'b0}};
        for (int i = 0; i < ENGS_N; i++) begin
            set_s = set_s | ((we_s[i] ? ONE_HOT0 : {DEPTH{1'b0}}) << wr_tag_i[i*TAG_W +: TAG_W]);
        end
        clr_s  = ((iss_clr_i ? ONE_HOT0 : {DEPTH{1'b0}}) << iss_tag_i)
               | ((ret_clr_i ? ONE_HOT0 : {DEPTH{1'b0}}) << ret_tag_i);
        done_d = (done_q & ~clr_s) | set_s;
    end

    // Done-vector register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            done_q <= {DEPTH{1'b0}};
        end else begin
            done_q <= done_d;
        end
    end

    // Payload storage; deliberately not reset (only observed once done is set).
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENGS_N; i++) begin
            if (we_s[i]) begin
                dat_q[wr_tag_i[i*TAG_W +: TAG_W]] <= wr_dat_i[i*DAT_W +: DAT_W];
            end
        end
    end

    assign rd_dat_o = dat_q[rd_tag_i];
    assign done_o   = done_q;

endmodule

// File: rtl/h_bdy_eng_ret.sv
// Body-engine return path: grants sequential tags at dispatch, collects
// out-of-order completions from ENGS_N engines into a reorder buffer and
// retires results strictly in tag order. Tag width is fixed by the package.
// Ports:
//   iss_vld/iss_rdy/iss_tag   tag grant handshake (iss_rdy = ROB not full)
//   cmp_vld/cmp_tag/cmp_dat   per-engine completion strobes, tags, payloads
//   out_vld/out_rdy/out_tag/out_dat  in-order retire handshake
//   err                       sticky protocol-violation flag
module h_bdy_eng_ret
    import h_bdy_eng_ret_pkg::*;
#(
    parameter int ENGS_N = ENGS_N_DEF,
    parameter int DAT_W  = DAT_W_DEF
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     iss_vld,
    output logic                     iss_rdy,
    output logic [TAG_W-1:0]         iss_tag,
    input  logic [ENGS_N-1:0]        cmp_vld,
    input  logic [ENGS_N*TAG_W-1:0]  cmp_tag,
    input  logic [ENGS_N*DAT_W-1:0]  cmp_dat,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [TAG_W-1:0]         out_tag,
    output logic [DAT_W-1:0]         out_dat,
    output logic                     err
);

    h_ptr_t hd_q, hd_d;
    h_ptr_t tl_q, tl_d;
    logic   err_q, err_d;

    h_tag_t            hd_idx_s;
    h_tag_t            tl_idx_s;
    logic              empty_s;
    logic              full_s;
    logic              iss_fire_s;
    logic              ret_fire_s;
    logic [DEPTH-1:0]  done_s;
    logic [ENGS_N-1:0] bad_s;
    logic [ENGS_N-1:0] wr_en_s;
    logic [ENGS_N-1:0] dup_s;

    assign hd_idx_s = hd_q[TAG_W-1:0];
    assign tl_idx_s = tl_q[TAG_W-1:0];
    assign empty_s  = (hd_q == tl_q);
    assign full_s   = (hd_idx_s == tl_idx_s) && (hd_q[TAG_W] != tl_q[TAG_W]);

    // Issue readiness comes only from registered pointers: a same-cycle
    // retire does not open a slot until the next cycle.
    assign iss_rdy    = !full_s;
    assign iss_tag    = tl_idx_s;
    assign iss_fire_s = iss_vld && !full_s;

    assign out_vld    = !empty_s && done_s[hd_idx_s];
    assign out_tag    = hd_idx_s;
    assign ret_fire_s = out_vld && out_rdy;
    assign err        = err_q;

    // Per-port legality: tag must be outstanding and not already done.
    always_comb begin
        bad_s = {ENGS_N{1'b0}};
        for (int i = 0; i < ENGS_N; i++) begin
            bad_s[i] = cmp_vld[i] &&
                       (!h_in_flight(hd_q, tl_q, cmp_tag[i*TAG_W +: TAG_W]) ||
                        done_s[cmp_tag[i*TAG_W +: TAG_W]]);
        end
    end

    // Offending ports never reach the ROB.
    assign wr_en_s = cmp_vld & ~bad_s;

    // Pointer and sticky-error next state.
    always_comb begin
        hd_d  = hd_q;
        tl_d  = tl_q;
        err_d = err_q | (|bad_s) | (|dup_s);
        if (iss_fire_s) begin
            tl_d = tl_q + PTR_ONE;
        end else begin
            tl_d = tl_q;
        end
        if (ret_fire_s) begin
            hd_d = hd_q + PTR_ONE;
        end else begin
            hd_d = hd_q;
        end
    end

    // Pointer and error registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            hd_q  <= PTR_ZERO;
            tl_q  <= PTR_ZERO;
            err_q <= 1'b0;
        end else begin
            hd_q  <= hd_d;
            tl_q  <= tl_d;
            err_q <= err_d;
        end
    end

    h_bdy_eng_ret_rob #(
        .ENGS_N (ENGS_N),
        .DAT_W  (DAT_W)
    ) u_rob (
        .clk       (clk),
        .arst_n    (arst_n),
        .wr_en_i   (wr_en_s),
        .wr_tag_i  (cmp_tag),
        .wr_dat_i  (cmp_dat),
        .iss_clr_i (iss_fire_s),
        .iss_tag_i (tl_idx_s),
        .ret_clr_i (ret_fire_s),
        .ret_tag_i (hd_idx_s),
        .rd_tag_i  (hd_idx_s),
        .rd_dat_o  (out_dat),
        .done_o    (done_s),
        .dup_o     (dup_s)
    );

endmodule
